// File: rtl/compressor_frame_accumulator.sv
// Streaming popcount/tally stage after a 5:3 counter: sums beat values {cout,carry,sum}
// over a frame and presents total/beats/overflow on a valid/ready port. Macro: ACC_SATURATE_EN.
module compressor_frame_accumulator #(
   parameter int ACC_W     = 16,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sum,
   input  logic             in_carry,
   input  logic             in_cout,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_ovf
);

   localparam logic [1:0]       S_IDLE   = 2'd0;
   localparam logic [1:0]       S_ACCUM  = 2'd1;
   localparam logic [1:0]       S_HOLD   = 2'd2;
   localparam logic [CNT_W-1:0] LP_FRAME = CNT_W'(FRAME_LEN);
   localparam logic [ACC_W-1:0] LP_MAX   = '1;

   logic [1:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_beats;
   logic             r_ovf;

   logic             w_accept;
   logic             w_first;
   logic             w_close;
   logic             w_ovf_now;
   logic [2:0]       w_v;
   logic [ACC_W-1:0] w_base;
   logic [ACC_W:0]   w_sum;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_beats_nxt;

   assign in_ready  = (r_state != S_HOLD);
   assign out_valid = (r_state == S_HOLD);
   assign w_accept  = in_valid & in_ready;
   assign w_first   = (r_state == S_IDLE);
   assign w_v       = {in_cout, in_carry, in_sum};

   // First beat of a frame starts from zero, so IDLE needs no separate clear cycle.
   assign w_base      = w_first ? '0 : r_acc;
   assign w_sum       = {1'b0, w_base} + (ACC_W+1)'(w_v);
   assign w_ovf_now   = w_sum[ACC_W];
   assign w_beats_nxt = (w_first ? '0 : r_beats) + CNT_W'(1);
   assign w_close     = in_last | (w_beats_nxt == LP_FRAME);

`ifdef ACC_SATURATE_EN
   assign w_acc_nxt = w_ovf_now ? LP_MAX : w_sum[ACC_W-1:0];
`else
   assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_beats <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ACCUM: begin
               if (w_accept) begin
                  r_acc   <= w_acc_nxt;
                  r_beats <= w_beats_nxt;
                  r_ovf   <= (w_first ? 1'b0 : r_ovf) | w_ovf_now;
                  r_state <= w_close ? S_HOLD : S_ACCUM;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_acc   <= '0;
                  r_beats <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Accumulator registers double as the held result while in HOLD.
   assign out_total = r_acc;
   assign out_beats = r_beats;
   assign out_ovf   = r_ovf;

endmodule
